fft_p2s: RTL and testbench
==========================

# fft_p2s

Parallel-to-serial drain for FFT frames: the reverse of the serial-to-parallel stage feeding the FFT. It captures all 16 32-bit bins in the cycle `fft_valid` pulses and streams them out one bin per beat over a valid/ready interface. Output order is bin 0 first, bin 15 last. It sits beside `Analysis` on the FFT output bus and feeds a downstream serial consumer (UART/DMA-style sink). A two-frame ping-pong buffer absorbs one new frame while the previous one is still draining.

## Interface
- `DW`, 32, bin width; `{real[DW-1:DW/2], imag[DW/2-1:0]}`, carried unmodified
- `CNT_W`, 8, width of the saturating drop counter
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — reset is synchronous and active-high
- `fft_valid` in 1 — one-cycle pulse; bins valid this cycle only
- `fft_d0`..`fft_d15` in DW each — FFT bins 0..15
- `out_ready` in 1 — sink accepts a beat
- `out_valid` out 1 — beat available
- `out_d` out DW — current bin; 0 when `out_valid`=0
- `out_idx` out 4 — bin index of current beat
- `out_last` out 1 — high with bin 15 beat (qualified by `out_valid`)
- `drop` out 1 — one-cycle pulse when an incoming frame is discarded
- `drop_cnt` out CNT_W — frames discarded since reset, saturates at all-ones

## Operation
- State: two buffers `buf[0]`, `buf[1]`; `wr_sel`, `rd_sel` (1 bit each); `pending` (0..2); `idx` (4 bits).
- Beat transfer: `out_valid && out_ready`.
- `out_valid` = (`pending` != 0).
- `out_d` = `buf[rd_sel][idx]` when valid, else 0.
- `out_idx` = `idx`.
- Per transfer: `idx` increments. On transfer with `idx`=15:
  - `idx` wraps to 0, `rd_sel` toggles, the frame is released.
- `free` = (`pending` < 2) OR (release this cycle). A frame whose last beat transfers in the same cycle as `fft_valid` frees its slot for that same frame, so no drop occurs.
- On `fft_valid` with `free`: all 16 bins load into `buf[wr_sel]`, and `wr_sel` toggles.
- On `fft_valid` without `free`: the frame is discarded, `drop`=1 next cycle, and `drop_cnt` increments (saturating). Buffers, pointers and `pending` are unchanged.
- `pending` next = `pending` + accept − release. Simultaneous accept and release leaves it unchanged.
- Handshake rules:
  - Once `out_valid` rises, `out_d`/`out_idx`/`out_last` hold stable until the transfer.
  - `out_valid` never drops mid-frame.
  - A loaded buffer is never overwritten before its bin 15 transfers.
- `out_ready` while `out_valid`=0 has no effect.
- Reset (any time, including mid-drain or coincident with `fft_valid`): all state clears and partial frames are lost. The `fft_valid` in the reset cycle is ignored.
- Reset values:
  - `out_valid`=0, `out_d`=0, `out_idx`=0, `out_last`=0, `drop`=0, `drop_cnt`=0.
  - Internal: `pending`=0, `wr_sel`=`rd_sel`=0, `idx`=0. Buffer contents don't care.

## Timing
- Capture latency: `fft_valid` at edge N → `out_valid`=1 with bin 0 after edge N+1 (one register stage).
- Throughput: 1 bin/cycle with `out_ready` held high, so a frame drains in 16 cycles.
- Frame spacing: frames arriving ≥16 cycles apart never drop under full ready. With 2 frames buffered, a third frame is accepted only in the cycle bin 15 of the oldest frame transfers.
- Back-to-back frames: bin 15 of frame A at cycle M is followed by bin 0 of frame B at cycle M+1, with no bubble.
- Outputs `out_*` are driven from registers through the read mux only. There is no combinational path from `out_ready` to `out_valid` or `out_d`.
- `drop` is registered, one cycle after the offending `fft_valid`.

## Structure
- Shared package `fas_pkg`:
  - `FFT_N`=16, `FFT_IDX_W`=4, `FFT_DW`=32.
  - typedef `fft_bin_t` (`logic signed [31:0]`).
  - typedef `fft_frame_t` (array of 16 `fft_bin_t`).
- Sub-module `p2s_frame_buf`: one 16×DW register bank with a `load` strobe, 16 parallel write inputs and a 4-bit read-index mux. Instantiated twice. The top holds the pointers, `pending`, `idx`, the handshake and the drop logic.

## Test plan
- Single frame, `fft_d`k = {16'(k), 16'(−k)}, `out_ready`=1:
  - `out_valid` rises 1 cycle after the pulse.
  - 16 consecutive beats with `out_idx` 0..15 and matching data.
  - `out_last` only on beat 15, then `out_valid`=0.
- Backpressure: `out_ready` toggling 1,0,0,1… with random stalls. Required:
  - All 16 bins arrive in order.
  - `out_d`/`out_idx` stay stable during each stall.
  - Frame completes only after 16 transfers.
- Two frames, pulses 3 cycles apart, `out_ready`=1:
  - 32 contiguous beats, frame A then frame B, no bubble.
  - `drop` never asserted.
- Overflow: `out_ready`=0, three pulses at cycles 0, 2, 4:
  - `drop` pulses at cycle 5 and `drop_cnt`=1.
  - With `out_ready` released, frames 1 and 2 drain intact and frame 3 is absent.
- Simultaneous release and accept, with 2 frames pending and `fft_valid` in the exact cycle bin 15 of the oldest frame transfers:
  - No drop, and `pending` stays 2.
  - The new frame follows the remaining frame.
- Reset mid-drain:
  - Assert `rst` at beat 7 of a frame, coincident with a new `fft_valid`.
  - Next cycle: all outputs 0 and `drop_cnt`=0.
  - A fresh frame afterwards drains from bin 0.

Source files
------------

// File: rtl/fas_pkg.sv
// fas_pkg: shared FFT frame constants and types
package fas_pkg;
  localparam int FFT_N = 16;
  localparam int FFT_IDX_W = 4;
  localparam int FFT_DW = 32;
  typedef logic signed [FFT_DW-1:0] fft_bin_t;
  typedef fft_bin_t fft_frame_t [FFT_N];
endpackage

// File: rtl/p2s_frame_buf.sv
// p2s_frame_buf: one frame register bank with parallel load and indexed read
module p2s_frame_buf
  import fas_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [DW-1:0]        wr_d [FFT_N],
  input  logic [FFT_IDX_W-1:0] rd_idx,
  output logic [DW-1:0]        rd_d
);
  logic [DW-1:0] mem [FFT_N];
  always_ff @(posedge clk)
    if (load) mem <= wr_d;
  assign rd_d = mem[rd_idx];
endmodule

// File: rtl/fft_p2s.sv
// fft_p2s: ping-pong parallel-to-serial drain of 16-bin FFT frames
module fft_p2s
  import fas_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_valid,
  input  logic [DW-1:0]        fft_d0,
  input  logic [DW-1:0]        fft_d1,
  input  logic [DW-1:0]        fft_d2,
  input  logic [DW-1:0]        fft_d3,
  input  logic [DW-1:0]        fft_d4,
  input  logic [DW-1:0]        fft_d5,
  input  logic [DW-1:0]        fft_d6,
  input  logic [DW-1:0]        fft_d7,
  input  logic [DW-1:0]        fft_d8,
  input  logic [DW-1:0]        fft_d9,
  input  logic [DW-1:0]        fft_d10,
  input  logic [DW-1:0]        fft_d11,
  input  logic [DW-1:0]        fft_d12,
  input  logic [DW-1:0]        fft_d13,
  input  logic [DW-1:0]        fft_d14,
  input  logic [DW-1:0]        fft_d15,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_d,
  output logic [FFT_IDX_W-1:0] out_idx,
  output logic                 out_last,
  output logic                 drop,
  output logic [CNT_W-1:0]     drop_cnt
);
  logic [DW-1:0] frame [FFT_N];
  logic [DW-1:0] rd0, rd1;
  logic [1:0] pending;
  logic [FFT_IDX_W-1:0] idx;
  logic wr_sel, rd_sel, xfer, rel, free, acc, rej;
  assign frame = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
  assign out_valid = pending != 2'd0;
  assign xfer = out_valid && out_ready;
  assign rel = xfer && idx == FFT_IDX_W'(FFT_N - 1);
  // releasing the oldest frame this cycle frees its slot for a coincident arrival
  assign free = pending < 2'd2 || rel;
  assign acc = fft_valid && free && !rst;
  assign rej = fft_valid && !free;
  p2s_frame_buf #(.DW(DW)) u_buf0 (
    .clk(clk), .load(acc && !wr_sel), .wr_d(frame), .rd_idx(idx), .rd_d(rd0)
  );
  p2s_frame_buf #(.DW(DW)) u_buf1 (
    .clk(clk), .load(acc && wr_sel), .wr_d(frame), .rd_idx(idx), .rd_d(rd1)
  );
  assign out_d = out_valid ? (rd_sel ? rd1 : rd0) : '0;
  assign out_idx = idx;
  assign out_last = out_valid && idx == FFT_IDX_W'(FFT_N - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      idx <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pending <= pending + 2'(acc) - 2'(rel);
      if (xfer) idx <= idx + FFT_IDX_W'(1);
      if (rel) rd_sel <= ~rd_sel;
      if (acc) wr_sel <= ~wr_sel;
      drop <= rej;
      if (rej && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fft_p2s.sv
// tb_fft_p2s: scoreboard bench for the FFT parallel-to-serial drain
module tb_fft_p2s;
  logic clk = 0, rst = 1, fft_valid = 0, out_ready = 0;
  logic [31:0] fd [16];
  logic out_valid, out_last, drop;
  logic [31:0] out_d;
  logic [3:0] out_idx;
  logic [7:0] drop_cnt;
  logic [36:0] q [$];
  logic [36:0] exp_beat, held;
  logic stall_prev = 0;
  int checks = 0, passes = 0, drop_seen = 0;

  always #5 clk = ~clk;

  fft_p2s dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .out_ready(out_ready), .out_valid(out_valid), .out_d(out_d), .out_idx(out_idx),
    .out_last(out_last), .drop(drop), .drop_cnt(drop_cnt)
  );

  function automatic logic [31:0] mk(int base, int k);
    return {16'(base + k), 16'(-(base + k))};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(int base);
    for (int k = 0; k < 16; k++) fd[k] = mk(base, k);
  endtask

  task automatic pulse(int base, bit accept);
    set_frame(base);
    fft_valid = 1;
    if (accept)
      for (int k = 0; k < 16; k++) q.push_back({4'(k), k == 15, mk(base, k)});
    tick();
    fft_valid = 0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 64'(q.size()), 64'd0);
    chk({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  task automatic wait_idx(int target);
    int n = 0;
    while (!(out_valid && out_idx == 4'(target)) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idx", 64'(out_valid && out_idx == 4'(target)), 64'd1);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) chk("stall_hold", 64'({out_valid, out_idx, out_last, out_d}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 64'({out_idx, out_last, out_d}), 64'hdead);
        else begin
          exp_beat = q.pop_front();
          chk("beat", 64'({out_idx, out_last, out_d}), 64'(exp_beat));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_idx, out_last, out_d};
      if (drop) drop_seen++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    set_frame(5000);
    fft_valid = 1;
    tick();
    tick();
    rst = 0;
    fft_valid = 0;
    chk("rst_outputs", 64'({out_valid, out_d, out_idx, out_last, drop, drop_cnt}), 64'd0);
    tick();
    chk("rst_pulse_ignored", 64'(out_valid), 64'd0);
    // single frame, full ready
    out_ready = 1;
    pulse(0, 1);
    chk("latency_valid", 64'({out_valid, out_idx}), 64'({1'b1, 4'd0}));
    wait_drain("single");
    // backpressure with pattern plus random stalls
    out_ready = 0;
    pulse(100, 1);
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      out_ready = (i % 4 == 0 || i % 4 == 3) && ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1;
    wait_drain("backpressure");
    // two frames 3 cycles apart, no bubble
    d0 = drop_seen;
    pulse(200, 1);
    for (int i = 0; i < 32; i++) begin
      chk("no_bubble", 64'(out_valid), 64'd1);
      if (i == 2) begin
        set_frame(300);
        fft_valid = 1;
        for (int k = 0; k < 16; k++) q.push_back({4'(k), k == 15, mk(300, k)});
      end
      tick();
      fft_valid = 0;
    end
    wait_drain("two_frames");
    chk("two_frames_nodrop", 64'(drop_seen), 64'(d0));
    // overflow: third frame while two are held
    out_ready = 0;
    pulse(400, 1);
    tick();
    pulse(500, 1);
    tick();
    pulse(600, 0);
    chk("ovf_drop", 64'({drop, drop_cnt}), 64'({1'b1, 8'd1}));
    tick();
    chk("ovf_drop_pulse", 64'(drop), 64'd0);
    out_ready = 1;
    wait_drain("overflow");
    // arrival in the exact cycle the oldest frame releases
    out_ready = 0;
    pulse(700, 1);
    pulse(800, 1);
    out_ready = 1;
    wait_idx(15);
    d0 = drop_seen;
    pulse(900, 1);
    chk("simul_nodrop", 64'({drop, drop_cnt}), 64'({1'b0, 8'd1}));
    chk("simul_next", 64'({out_valid, out_idx, out_d}), 64'({1'b1, 4'd0, mk(800, 0)}));
    wait_drain("simul");
    chk("simul_nodrop_all", 64'(drop_seen), 64'(d0));
    // reset mid-drain with coincident fft_valid
    pulse(1000, 1);
    wait_idx(7);
    set_frame(1100);
    fft_valid = 1;
    rst = 1;
    tick();
    rst = 0;
    fft_valid = 0;
    q.delete();
    chk("midrst_outputs", 64'({out_valid, out_d, out_idx, out_last, drop, drop_cnt}), 64'd0);
    tick();
    chk("midrst_idle", 64'(out_valid), 64'd0);
    pulse(1200, 1);
    chk("midrst_fresh", 64'({out_valid, out_idx, out_d}), 64'({1'b1, 4'd0, mk(1200, 0)}));
    wait_drain("fresh");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
